// File: rtl/sd_cmd_sequencer.sv
// SD command-path sequencer: two-port round-robin arbitration, transmit tracking, response window and gap.
// Define SD_CMD_SEQ_RETRY_EN to re-issue a command up to MAX_RETRY times after a response timeout.
module sd_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 8,
    parameter int TX_GUARD       = 32
) (
    input  logic        sd_clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [37:0] cmd0,
    input  logic [37:0] cmd1,
    input  logic        resp0,
    input  logic        resp1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        send_en,
    output logic [37:0] cmd_content,
    input  logic        tx_busy,
    input  logic        sd_cmd_in,
    output logic        rx_start
);

    localparam int CNT_MAX_A = (TIMEOUT_CYCLES > TX_GUARD) ? TIMEOUT_CYCLES : TX_GUARD;
    localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, TX_WAIT, TX_RUN, RESP_WAIT, GAP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic               resp_q, resp_d;
    logic [37:0]        content_d;
    logic [1:0]         grant_d, done_d, err_d;
    logic               send_en_d, rx_start_d;

`ifdef SD_CMD_SEQ_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTY_W-1:0]   retry_q, retry_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        resp_d     = resp_q;
        content_d  = cmd_content;
        grant_d    = grant;
        send_en_d  = 1'b0;
        done_d     = 2'b00;
        err_d      = 2'b00;
        rx_start_d = 1'b0;
`ifdef SD_CMD_SEQ_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // With both requesting, the port not served last wins
                    owner_d   = (req0 && req1) ? ~last_q : req1;
                    grant_d   = owner_d ? 2'b10 : 2'b01;
                    content_d = owner_d ? cmd1 : cmd0;
                    resp_d    = owner_d ? resp1 : resp0;
`ifdef SD_CMD_SEQ_RETRY_EN
                    retry_d   = '0;
`endif
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                send_en_d = 1'b1;
                cnt_d     = '0;
                state_d   = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_busy) begin
                    state_d = TX_RUN;
                end else if (cnt_q == CNT_W'(TX_GUARD - 1)) begin
                    err_d   = grant;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            TX_RUN: begin
                if (!tx_busy) begin
                    cnt_d = '0;
                    if (resp_q) begin
                        state_d = RESP_WAIT;
                    end else begin
                        done_d  = grant;
                        state_d = GAP;
                    end
                end
            end
            RESP_WAIT: begin
                if (!sd_cmd_in) begin
                    rx_start_d = 1'b1;
                    done_d     = grant;
                    cnt_d      = '0;
                    state_d    = GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cnt_d   = '0;
`ifdef SD_CMD_SEQ_RETRY_EN
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = ISSUE;
                    end else begin
                        err_d   = grant;
                        state_d = GAP;
                    end
`else
                    err_d   = grant;
                    state_d = GAP;
`endif
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    grant_d = 2'b00;
                    last_d  = owner_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sd_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            resp_q      <= 1'b0;
            cmd_content <= '0;
            grant       <= 2'b00;
            done        <= 2'b00;
            err         <= 2'b00;
            send_en     <= 1'b0;
            rx_start    <= 1'b0;
`ifdef SD_CMD_SEQ_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            resp_q      <= resp_d;
            cmd_content <= content_d;
            grant       <= grant_d;
            done        <= done_d;
            err         <= err_d;
            send_en     <= send_en_d;
            rx_start    <= rx_start_d;
`ifdef SD_CMD_SEQ_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer with default parameters (64/3/8/32).
module tb_sd_cmd_sequencer;

    logic        sd_clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [37:0] cmd0 = '0, cmd1 = '0;
    logic        resp0 = 1'b0, resp1 = 1'b0;
    logic [1:0]  grant, done, err;
    logic        send_en, rx_start;
    logic [37:0] cmd_content;
    logic        tx_busy = 1'b0;
    logic        sd_cmd_in = 1'b1;

    int total = 0;
    int bad = 0;

    sd_cmd_sequencer dut (
        .sd_clk(sd_clk), .reset(reset),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .resp0(resp0), .resp1(resp1),
        .grant(grant), .done(done), .err(err),
        .send_en(send_en), .cmd_content(cmd_content),
        .tx_busy(tx_busy), .sd_cmd_in(sd_cmd_in), .rx_start(rx_start)
    );

    always #5 sd_clk = ~sd_clk;

    task automatic tick;
        @(posedge sd_clk);
        #1;
    endtask

    task automatic do_reset;
        req0 = 1'b0; req1 = 1'b0; resp0 = 1'b0; resp1 = 1'b0;
        tx_busy = 1'b0; sd_cmd_in = 1'b1;
        reset = 1'b1;
        repeat (2) tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        cmd0 = 38'h15_5555_5555;
        reset = 1'b1;
        #1;
        total++;
        if ({grant, done, err, send_en, rx_start, cmd_content} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %0h want 0", {grant, done, err, send_en, rx_start, cmd_content});
        end
        tick;
        reset = 1'b0;
    endtask

    task automatic test_single;
        int n;
        do_reset;
        cmd0 = 38'h0; resp0 = 1'b0; req0 = 1'b1;
        tick;
        total++;
        if (grant !== 2'b01 || send_en !== 1'b0) begin
            bad++; $display("FAIL single_grant: got grant=%b send_en=%b want 01/0", grant, send_en);
        end
        tick;
        total++;
        if (send_en !== 1'b1) begin
            bad++; $display("FAIL single_send_en: got %b want 1", send_en);
        end
        tx_busy = 1'b1;
        tick;
        total++;
        if (send_en !== 1'b0) begin
            bad++; $display("FAIL single_send_pulse: got %b want 0", send_en);
        end
        repeat (47) tick;
        tx_busy = 1'b0;
        tick;
        total++;
        if (done !== 2'b01 || err !== 2'b00) begin
            bad++; $display("FAIL single_done: got done=%b err=%b want 01/00", done, err);
        end
        req0 = 1'b0;
        n = 0;
        while (grant !== 2'b00 && n < 50) begin
            tick;
            n++;
        end
        total++;
        if (n != 8) begin
            bad++; $display("FAIL single_gap: got %0d cycles want 8", n);
        end
    endtask

    task automatic test_response;
        int n;
        bit seen;
        do_reset;
        cmd1 = 38'h2A_1234_5678; resp1 = 1'b1; req1 = 1'b1;
        tick;
        total++;
        if (grant !== 2'b10 || cmd_content !== 38'h2A_1234_5678) begin
            bad++; $display("FAIL resp_grant: got grant=%b content=%h want 10/2a12345678", grant, cmd_content);
        end
        cmd1 = '0; resp1 = 1'b0;
        tick;
        tx_busy = 1'b1;
        repeat (10) tick;
        tx_busy = 1'b0;
        tick;
        total++;
        if (done !== 2'b00 || cmd_content !== 38'h2A_1234_5678) begin
            bad++; $display("FAIL resp_latched: got done=%b content=%h want 00/2a12345678", done, cmd_content);
        end
        seen = 1'b0;
        repeat (19) begin
            tick;
            if (rx_start !== 1'b0 || done !== 2'b00 || err !== 2'b00) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL resp_early: got early pulse want none");
        end
        sd_cmd_in = 1'b0;
        tick;
        total++;
        if (rx_start !== 1'b1 || done !== 2'b10 || err !== 2'b00) begin
            bad++; $display("FAIL resp_found: got rx=%b done=%b err=%b want 1/10/00", rx_start, done, err);
        end
        sd_cmd_in = 1'b1; req1 = 1'b0;
        tick;
        total++;
        if (rx_start !== 1'b0 || done !== 2'b00) begin
            bad++; $display("FAIL resp_pulse: got rx=%b done=%b want 0/00", rx_start, done);
        end
        n = 0;
        while (grant !== 2'b00 && n < 50) begin tick; n++; end
    endtask

    task automatic test_retry;
        int sends, tx_left, k, k_drop, k_err, exp_sends;
        bit prev_busy, got_done;
`ifdef SD_CMD_SEQ_RETRY_EN
        exp_sends = 4;
`else
        exp_sends = 1;
`endif
        do_reset;
        cmd0 = 38'h05_0000_00AA; resp0 = 1'b1; req0 = 1'b1;
        sends = 0; tx_left = 0; k_drop = 0; k_err = -1; prev_busy = 1'b0; got_done = 1'b0;
        for (k = 1; k < 1000 && k_err < 0; k++) begin
            tick;
            if (send_en === 1'b1) begin sends++; tx_left = 5; end
            if (done !== 2'b00) got_done = 1'b1;
            if (err !== 2'b00) k_err = k;
            tx_busy = (tx_left > 0);
            if (tx_left > 0) tx_left--;
            if (prev_busy && !tx_busy) k_drop = k;
            prev_busy = tx_busy;
        end
        total++;
        if (k_err < 0 || err !== 2'b01 || got_done) begin
            bad++; $display("FAIL retry_err: got err=%b done_seen=%b want 01/0", err, got_done);
        end
        total++;
        if (sends != exp_sends) begin
            bad++; $display("FAIL retry_sends: got %0d want %0d", sends, exp_sends);
        end
        total++;
        if (k_err - k_drop != 65) begin
            bad++; $display("FAIL retry_window: got %0d want 65", k_err - k_drop);
        end
        req0 = 1'b0;
        k = 0;
        while (grant !== 2'b00 && k < 50) begin tick; k++; end
    endtask

    task automatic test_contention;
        logic [1:0] g [3];
        int ng, k, tx_left, k_done, gap_err;
        logic [1:0] prev_grant;
        do_reset;
        resp0 = 1'b0; resp1 = 1'b0; req0 = 1'b1; req1 = 1'b1;
        ng = 0; tx_left = 0; k_done = -1; gap_err = 0; prev_grant = 2'b00;
        for (k = 1; k < 2000 && ng < 3; k++) begin
            tick;
            if (prev_grant === 2'b00 && grant !== 2'b00) begin
                g[ng] = grant;
                ng++;
                if (k_done >= 0 && k - k_done != 9) gap_err++;
            end
            if (done !== 2'b00) k_done = k;
            if (send_en === 1'b1) tx_left = 4;
            tx_busy = (tx_left > 0);
            if (tx_left > 0) tx_left--;
            prev_grant = grant;
        end
        total++;
        if (ng != 3 || g[0] !== 2'b01 || g[1] !== 2'b10 || g[2] !== 2'b01) begin
            bad++; $display("FAIL contention_order: got n=%0d %b %b %b want 3 01 10 01", ng, g[0], g[1], g[2]);
        end
        total++;
        if (gap_err != 0) begin
            bad++; $display("FAIL contention_gap: got %0d bad gaps want 0", gap_err);
        end
        req0 = 1'b0; req1 = 1'b0;
        do_reset;
    endtask

    task automatic test_guard;
        int n, extra;
        do_reset;
        resp0 = 1'b0; req0 = 1'b1;
        tick;
        tick;
        total++;
        if (send_en !== 1'b1) begin
            bad++; $display("FAIL guard_send: got %b want 1", send_en);
        end
        n = 0; extra = 0;
        while (err === 2'b00 && n < 100) begin
            tick;
            n++;
            if (send_en === 1'b1) extra++;
        end
        total++;
        if (n != 32 || err !== 2'b01 || done !== 2'b00) begin
            bad++; $display("FAIL guard_err: got n=%0d err=%b done=%b want 32/01/00", n, err, done);
        end
        req0 = 1'b0;
        repeat (12) begin
            tick;
            if (send_en === 1'b1) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++; $display("FAIL guard_resend: got %0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        do_reset;
        cmd1 = 38'h11_0000_0001; resp1 = 1'b1; req1 = 1'b1;
        tick;
        tick;
        tx_busy = 1'b1;
        repeat (3) tick;
        tx_busy = 1'b0;
        tick;
        repeat (5) tick;
        reset = 1'b1;
        #1;
        total++;
        if ({grant, done, err, send_en, rx_start, cmd_content} !== '0) begin
            bad++; $display("FAIL midreset_outputs: got %0h want 0", {grant, done, err, send_en, rx_start, cmd_content});
        end
        tick;
        reset = 1'b0; req1 = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            tick;
            if (done !== 2'b00 || err !== 2'b00 || grant !== 2'b00) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL midreset_quiet: got activity after reset want none");
        end
        cmd0 = 38'h08_0000_01AA; resp0 = 1'b0; req0 = 1'b1;
        tick;
        total++;
        if (grant !== 2'b01 || cmd_content !== 38'h08_0000_01AA) begin
            bad++; $display("FAIL midreset_regrant: got grant=%b content=%h want 01/08000001aa", grant, cmd_content);
        end
        tick;
        tx_busy = 1'b1;
        tick;
        tx_busy = 1'b0;
        tick;
        total++;
        if (done !== 2'b01) begin
            bad++; $display("FAIL midreset_done: got %b want 01", done);
        end
        req0 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_response;
        test_retry;
        test_contention;
        test_guard;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_cmd_sequencer.md
# sd_cmd_sequencer

Command-path sequencer that sits in front of the SD command transmitter (`sd_send`). It arbitrates between two command requesters: port 0 is the init engine and port 1 is the data/host engine. For the granted requester it latches the 38-bit command content, pulses the transmitter's `send_en`, and tracks the transmission through the transmitter's `finished` flag. It then watches the CMD line for the card's response start bit within a bounded window and retries on timeout. Finally it enforces the inter-command gap before the next grant.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: response window in sd_clk cycles (NCR max), measured after TX end.
- `MAX_RETRY`, 3: re-issues allowed after a response timeout.
- `GAP_CYCLES`, 8: minimum idle cycles between commands (NCC).
- `TX_GUARD`, 32: maximum cycles to wait for the transmitter to start.

Ports:
- `sd_clk`, in, 1: SD clock; all logic is in this domain.
- `reset`, in, 1: asynchronous, active-high.
- `req0` / `req1`, in, 1: command request; held high until `done`/`err` for that port.
- `cmd0` / `cmd1`, in, 38: {index[5:0], arg[31:0]} content.
- `resp0` / `resp1`, in, 1: 1 = a response is expected.
- `grant`, out, 2: one-hot owner of the command path.
- `done`, out, 2: one-cycle pulse on success, per port.
- `err`, out, 2: one-cycle pulse on failure, per port.
- `send_en`, out, 1: one-cycle pulse to the transmitter.
- `cmd_content`, out, 38: latched content of the granted command.
- `tx_busy`, in, 1: transmitter `finished` flag; high while the transmitter is shifting.
- `sd_cmd_in`, in, 1: sampled CMD line.
- `rx_start`, out, 1: one-cycle pulse when the response start bit is seen.

## Operation
- States: IDLE, ISSUE, TX_WAIT, TX_RUN, RESP_WAIT, GAP.
- IDLE:
  - If any req is high, grant it. Both requests high are resolved round-robin: the port not served last wins. After reset, port 0 wins.
  - On grant, latch `cmdN` into `cmd_content`, latch `respN`, clear the retry counter, and go to ISSUE.
- ISSUE: `send_en`=1 for exactly one cycle, then TX_WAIT.
- TX_WAIT:
  - When `tx_busy` goes high, go to TX_RUN.
  - If `tx_busy` has not risen after `TX_GUARD` cycles, pulse `err[owner]` with no retry and go to GAP.
- TX_RUN:
  - When `tx_busy` falls, go to RESP_WAIT if resp was latched.
  - Otherwise pulse `done[owner]` and go to GAP.
- RESP_WAIT:
  - The counter runs 1..`TIMEOUT_CYCLES`. A sample of `sd_cmd_in`=0 at any count causes a `rx_start` pulse and a `done[owner]` pulse in the same cycle, then GAP.
  - If all samples are 1, it is a timeout. If the retry count is below `MAX_RETRY`, increment it and go to ISSUE (same latched content).
  - Otherwise pulse `err[owner]` and go to GAP.
- GAP: count `GAP_CYCLES` cycles, drop `grant`, and record the last-served port. Then IDLE.
- `grant` stays high from the grant cycle through the end of GAP.
- Requester input changes after grant are ignored: content and resp stay latched. A req dropping mid-operation does not abort the command.
- Counters saturate and never wrap. The retry counter width is clog2(`MAX_RETRY`+1).

## Timing
- Reset values: every output is 0 (`grant`, `done`, `err`, `send_en`, `cmd_content`, `rx_start`). State is IDLE and the round-robin pointer is set so that port 0 wins.
- Reset asserted mid-operation: immediate return to IDLE with no `done`/`err` pulse.
- All outputs are registered.
- Latency from req high in IDLE:
  - cycle +1: `grant`
  - cycle +2: `send_en`
- Response window: count 1 is the first posedge after TX_RUN sees `tx_busy`=0.
- On success, `done` asserts the cycle after the start bit is sampled.
- From a `done`/`err` pulse to the next possible grant: `GAP_CYCLES`+1 cycles.
- A req arriving during GAP waits. No preemption.

## Configuration
- `SD_CMD_SEQ_RETRY_EN` defined: the timeout retry loop operates as described, up to `MAX_RETRY` re-issues.
- `SD_CMD_SEQ_RETRY_EN` not defined:
  - The first response timeout pulses `err` directly.
  - The retry counter is not built.
  - `MAX_RETRY` is ignored.

## Test plan
- Single request, no response: req0=1, cmd0=38'h0000000000, resp0=0, with `tx_busy` high for 48 cycles.
  - Required: `send_en` at cycle 2, `done[0]` after `tx_busy` falls, `grant` clears 8 cycles later.
- Response found: req1 with resp1=1, `sd_cmd_in` driven low 20 cycles after TX end.
  - Required: `rx_start` and `done[1]` pulse together, `err`=0.
- Retry exhaustion: resp0=1, `sd_cmd_in` held 1.
  - With the macro: 4 `send_en` pulses, then `err[0]`.
  - Without the macro: 1 `send_en` pulse, then `err[0]`.
- Contention: req0 and req1 high simultaneously after reset, both held.
  - Required: port 0 served first, port 1 served next, port 0 again if both are still requesting.
- TX guard: `tx_busy` never rises.
  - Required: `err` 32 cycles after TX_WAIT entry, with no second `send_en`.
- Reset mid-RESP_WAIT.
  - Required: all outputs 0 the same cycle, no `done`/`err`, and the next request is granted normally.
